pwm_bank: RTL
=============

# pwm_bank

Parametrised multi-channel PWM generator, the successor to the fixed 16-channel, shared-duty PWM peripheral. It sits behind the SPI register-write path and drives the chip's output pins. Over its predecessor it adds a per-channel duty cycle, a programmable prescaler and a global run bit. It also adds optional double-buffered duty updates that take effect at period boundaries, and a period-boundary strobe.

## Interface
Parameters:
- CH, 16, channel count, legal range 1..32
- PRESC_W, 8, prescaler register width, legal range 1..8

Ports:
- clk  in  1  system clock; all state in this block is clocked by it
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- wr_en  in  1  register write strobe; one write per cycle it is high
- wr_addr  in  8  register address
- wr_data  in  8  register write data
- out  out  CH  registered PWM/static outputs, one bit per channel
- period_end  out  1  one-cycle pulse at each PWM period wrap (registered)

## Operation
Register map. Every register resets to 0 except CTRL.
- 0x00..0x03 OUT_EN bytes: byte k holds channels 8k..8k+7.
- 0x04..0x07 PWM_EN bytes: same layout as OUT_EN.
- 0x08 PRESC: the counter advances once every PRESC+1 clocks.
- 0x09 CTRL: bit0 RUN, bit1 SYNC; reset value 0x01.
- 0x10..0x10+CH-1 DUTY[ch]: 8-bit duty shadow register for channel ch.
- Writes to unmapped addresses are ignored.
- Bits for channels >= CH are dropped, as are unused PRESC/CTRL bits.

Timebase:
- A prescaler counter counts 0..PRESC; it emits `tick` when it equals PRESC, then clears.
- The 8-bit period counter `cnt` advances on tick and runs 0..254, then wraps to 0, giving 255 steps per period.
- RUN=0: prescaler and `cnt` are held at 0, `period_end` stays 0, and all PWM levels are 0.

Duty handling:
- Writes go to the shadow register.
- SYNC=0: the active duty is loaded from wr_data on the same edge as the write.
- SYNC=1: all active duties load from their shadows on the edge where `cnt` wraps 254→0.
- A write on the same edge as the wrap, with SYNC=1: the shadow takes the new value, the active duty takes the old shadow, and the new value applies one period later.
- Clearing SYNC does not flush pending shadows; they load on the next wrap or on their next write.

Output function per channel:
- level = (duty == 0xFF) ? 1 : (cnt < duty).
- out[ch] = OUT_EN ? (PWM_EN ? (RUN & level) : 1) : 0.
- Consequences: duty 0x00 gives constant low, 0xFF gives constant high, and 0x80 gives 128 high / 127 low steps.

## Timing
- Reset: `out`=0, `period_end`=0, `cnt`=0, prescaler=0, all registers 0, CTRL=0x01.
- Reset asserted mid-period clears everything immediately (asynchronously), including pending shadows.
- Write at edge t updates the register; `out` reflects it after edge t+1 (1-cycle output latency).
- Output latency from `cnt` to `out` is 1 cycle; the period length is 255×(PRESC+1) clocks.
- `period_end` is high for exactly one clock: the cycle in which registered `cnt` first equals 0 after a wrap.
- A PRESC write takes effect at once. If the prescaler count already exceeds the new value, the prescaler clears on the next clock without emitting tick.
- RUN 1→0: `cnt` is 0 on the next edge. RUN 0→1: counting starts from 0, and the first `period_end` comes after a full period.

## Structure
- Package pwm_bank_pkg holds:
  - address constants ADDR_OUT_EN, ADDR_PWM_EN, ADDR_PRESC, ADDR_CTRL, ADDR_DUTY_BASE
  - CTRL bit indices CTRL_RUN, CTRL_SYNC
  - CTRL_RESET = 8'h01
  - CNT_MAX = 8'd254
- Sub-module pwm_timebase holds the prescaler, `cnt`, `tick`, wrap detect and `period_end` flop.
- pwm_bank holds the register file, shadow/active duty arrays and the output comparators.

## Test plan
- Reset: hold rst_n low for 3 clocks, release → out==0, period_end==0; a channel enabled with duty 0x80 toggles, proving RUN reset value 1.
- Static enable: write 0x00←0x01 (OUT_EN ch0) with PWM_EN=0 → out[0]==1 from edge t+1; write 0x04←0x01 with duty 0 → out[0]==0.
- Duty sweep, PRESC=0, SYNC=0, ch0 enabled:
  - duty 0x80 → 128 clocks high, 127 low, period_end every 255 clocks
  - duty 0x00 → constant 0
  - duty 0xFF → constant 1
- Double buffer, SYNC=1, ch3 duty 0x40: write 0xC0 at cnt==100 → period keeps 64 high clocks; next period has 192 high clocks. A write landing on the wrap edge is deferred one further period.
- Prescaler and run: PRESC=3, duty 0x80 → period 1020 clocks with 512 high; clear RUN mid-period → PWM outputs 0 and period_end silent; set RUN → restart at cnt 0.
- Bounds: CH=5 build; write 0x00←0xFF then 0x15 (DUTY ch5, unmapped) → out==5'h1F only and no state change; rst_n low mid-period → all outputs 0 within the same cycle.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: register map, CTRL bit positions, reset constants and the
// per-channel PWM level function shared by the pwm_bank slice.
package pwm_bank_pkg;

  localparam logic [7:0] ADDR_OUT_EN    = 8'h00;
  localparam logic [7:0] ADDR_PWM_EN    = 8'h04;
  localparam logic [7:0] ADDR_PRESC     = 8'h08;
  localparam logic [7:0] ADDR_CTRL      = 8'h09;
  localparam logic [7:0] ADDR_DUTY_BASE = 8'h10;

  localparam int unsigned CTRL_RUN  = 0;
  localparam int unsigned CTRL_SYNC = 1;

  localparam logic [7:0] CTRL_RESET = 8'h01;
  localparam logic [7:0] CNT_MAX    = 8'd254;

  // Duty 0xFF is forced high so that full scale is a constant level even
  // though cnt never reaches 255.
  function automatic logic pwm_level(input logic [7:0] duty, input logic [7:0] cnt);
    return (duty == 8'hFF) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// pwm_bank_if: register write port of pwm_bank.
//   wr_en   - write strobe, one write per cycle it is high
//   wr_addr - register address
//   wr_data - register write data
interface pwm_bank_if;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler and 255-step period counter for pwm_bank.
//   clk, rst_n  - clock, asynchronous active-low reset
//   run         - counting enable; when low prescaler and cnt are held at 0
//   presc       - prescaler terminal value (cnt advances every presc+1 clocks)
//   cnt         - registered period counter, 0..254
//   wrap        - high in the cycle whose edge takes cnt from 254 to 0
//   period_end  - registered one-cycle pulse while cnt first reads 0 after a wrap
module pwm_timebase
  import pwm_bank_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [PRESC_W-1:0] presc,
  output logic [7:0]         cnt,
  output logic               wrap,
  output logic               period_end
);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               period_end_q, period_end_d;
  logic               tick;

  assign tick = run && (presc_cnt_q == presc);
  assign wrap = tick && (cnt_q == CNT_MAX);

  always_comb begin
    presc_cnt_d  = presc_cnt_q + 1'b1;
    cnt_d        = cnt_q;
    period_end_d = wrap;
    if (!run) begin
      presc_cnt_d = '0;
      cnt_d       = '0;
    end else if (presc_cnt_q >= presc) begin
      // '>' only after presc was lowered below the running count: clear, no tick
      presc_cnt_d = '0;
      if (tick) begin
        cnt_d = wrap ? '0 : cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_q  <= '0;
      cnt_q        <= '0;
      period_end_q <= 1'b0;
    end else begin
      presc_cnt_q  <= presc_cnt_d;
      cnt_q        <= cnt_d;
      period_end_q <= period_end_d;
    end
  end

  assign cnt        = cnt_q;
  assign period_end = period_end_q;

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: CH-channel PWM generator with per-channel duty, prescaler,
// global run bit and optional period-synchronous (double-buffered) duty updates.
//   clk, rst_n  - clock, asynchronous active-low reset
//   bus         - register write port (pwm_bank_if.slave)
//   out         - registered per-channel PWM/static outputs
//   period_end  - registered one-cycle pulse at each period wrap
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int CH      = 16,
  parameter int PRESC_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  pwm_bank_if.slave     bus,
  output logic [CH-1:0] out,
  output logic          period_end
);

  logic [CH-1:0]      out_en_q, out_en_d;
  logic [CH-1:0]      pwm_en_q, pwm_en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               run_q, run_d;
  logic               sync_q, sync_d;
  logic [CH-1:0][7:0] shadow_q, shadow_d;
  logic [CH-1:0][7:0] active_q, active_d;
  logic [CH-1:0]      out_q, out_d;
  logic [7:0]         cnt;
  logic               wrap;

  pwm_timebase #(.PRESC_W(PRESC_W)) u_timebase (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run_q),
    .presc      (presc_q),
    .cnt        (cnt),
    .wrap       (wrap),
    .period_end (period_end)
  );

  always_comb begin
    out_en_d = out_en_q;
    pwm_en_d = pwm_en_q;
    presc_d  = presc_q;
    run_d    = run_q;
    sync_d   = sync_q;
    shadow_d = shadow_q;
    active_d = active_q;

    // Every wrap loads all shadows, regardless of SYNC: with SYNC=0 they already
    // equal the active duty except for writes left pending when SYNC was cleared.
    // A same-edge write below overrides only its shadow (or, with SYNC=0, its
    // active duty), so the wrap-time load uses the old shadow.
    if (wrap) begin
      active_d = shadow_q;
    end

    if (bus.wr_en) begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (bus.wr_addr == 8'(ADDR_OUT_EN + i / 8)) begin
          out_en_d[i] = bus.wr_data[3'(i % 8)];
        end
        if (bus.wr_addr == 8'(ADDR_PWM_EN + i / 8)) begin
          pwm_en_d[i] = bus.wr_data[3'(i % 8)];
        end
        if (bus.wr_addr == 8'(ADDR_DUTY_BASE + i)) begin
          shadow_d[i] = bus.wr_data;
          if (!sync_q) begin
            active_d[i] = bus.wr_data;
          end
        end
      end
      if (bus.wr_addr == ADDR_PRESC) begin
        presc_d = bus.wr_data[PRESC_W-1:0];
      end
      if (bus.wr_addr == ADDR_CTRL) begin
        run_d  = bus.wr_data[CTRL_RUN];
        sync_d = bus.wr_data[CTRL_SYNC];
      end
    end
  end

  always_comb begin
    out_d = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      out_d[i] = out_en_q[i] & (~pwm_en_q[i] | (run_q & pwm_level(active_q[i], cnt)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_en_q <= '0;
      pwm_en_q <= '0;
      presc_q  <= '0;
      run_q    <= CTRL_RESET[CTRL_RUN];
      sync_q   <= CTRL_RESET[CTRL_SYNC];
      shadow_q <= '0;
      active_q <= '0;
      out_q    <= '0;
    end else begin
      out_en_q <= out_en_d;
      pwm_en_q <= pwm_en_d;
      presc_q  <= presc_d;
      run_q    <= run_d;
      sync_q   <= sync_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      out_q    <= out_d;
    end
  end

  assign out = out_q;

endmodule
